// File: rtl/cal_pkg.sv
// Calendar clock shared definitions.
// Holds the month numbering, per-field limits, the date/time field
// bundle used for the running clock state, and the Gregorian
// days-in-month helper used for both rollover and load validation.
package cal_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [4:0] HOUR_MAX  = 5'd23;
    localparam logic [3:0] MONTH_MAX = DEC;
    localparam logic [3:0] MONTH_MIN = JAN;
    localparam logic [4:0] DAY_MIN   = 5'd1;

    // Everything below the year; the year width is a parameter of the top.
    typedef struct packed {
        logic [3:0] month;
        logic [4:0] day;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } cal_mdhms_t;

    // Gregorian rule: every 4th year, except centuries not divisible by 400.
    function automatic logic is_leap(input logic [31:0] year);
        return (((year % 32'd4) == 32'd0) && ((year % 32'd100) != 32'd0)) ||
               ((year % 32'd400) == 32'd0);
    endfunction

    // Out-of-range month codes fall to 31; callers range-check the month separately.
    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [31:0] year);
        logic [4:0] days;
        case (month)
            FEB: begin
                if (is_leap(year)) begin
                    days = 5'd29;
                end else begin
                    days = 5'd28;
                end
            end
            APR, JUN, SEP, NOV: days = 5'd30;
            default:            days = 5'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/cal_days_in_month.sv
// Combinational days-in-month lookup for a given month and year.
// Ports:
//   month - month code 1..12 (other codes report 31)
//   year  - full year, YEAR_W bits
//   days  - number of days in that month (28..31)
import cal_pkg::*;

module cal_days_in_month #(
    parameter int unsigned YEAR_W = 32'd12
) (
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [4:0]        days
);

    assign days = days_in_month(month, 32'(year));

endmodule

// File: rtl/calendar_clock_alarm.sv
// Free-running calendar clock with Gregorian leap handling, validated
// run-time load and an hour:minute alarm.
// Ports:
//   MAX10_CLK1_50 - system clock (rising edge)
//   KEY           - synchronous active-high reset
//   set_*         - load request (set_valid) and the date/time to load
//   alarm_*       - alarm write strobe, alarm time and level enable
//   out_*         - current date/time, registered
//   sec_tick      - one-cycle pulse on every one-second advance
//   set_err       - one-cycle pulse when a load request is rejected
//   alarm_hit     - one-cycle pulse when a tick lands on HH:MM:00 of the alarm
import cal_pkg::*;

module calendar_clock_alarm #(
    parameter int unsigned DIV_CONST = 32'd50000000,
    parameter int unsigned YEAR_W    = 32'd12,
    parameter int unsigned YEAR_INIT = 32'd2000
) (
    input  logic              MAX10_CLK1_50,
    input  logic              KEY,
    input  logic              set_valid,
    input  logic [YEAR_W-1:0] set_year,
    input  logic [3:0]        set_month,
    input  logic [4:0]        set_day,
    input  logic [4:0]        set_hour,
    input  logic [5:0]        set_min,
    input  logic [5:0]        set_sec,
    input  logic              alarm_we,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    input  logic              alarm_en,
    output logic [YEAR_W-1:0] out_year,
    output logic [3:0]        out_month,
    output logic [4:0]        out_day,
    output logic [4:0]        out_hour,
    output logic [5:0]        out_min,
    output logic [5:0]        out_sec,
    output logic              sec_tick,
    output logic              set_err,
    output logic              alarm_hit
);

    localparam int unsigned       PRESC_W    = (DIV_CONST > 32'd1) ? $clog2(DIV_CONST) : 32'd1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV_CONST - 32'd1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(32'd1);
    localparam logic [YEAR_W-1:0]  YEAR_LAST  = {YEAR_W{1'b1}};
    localparam logic [YEAR_W-1:0]  YEAR_START = YEAR_W'(YEAR_INIT);
    localparam logic [YEAR_W-1:0]  YEAR_ONE   = YEAR_W'(32'd1);

    logic [PRESC_W-1:0] presc_r;
    logic [YEAR_W-1:0]  year_r;
    cal_mdhms_t         mdhms_r;
    logic [4:0]         alarm_hour_r;
    logic [5:0]         alarm_min_r;
    logic               sec_tick_r;
    logic               set_err_r;
    logic               alarm_hit_r;

    logic [4:0]         run_dim_s;
    logic [4:0]         set_dim_s;
    logic               tick_s;
    logic               set_ok_s;
    logic               load_s;
    logic               advance_s;
    logic               hit_s;
    logic [YEAR_W-1:0]  nxt_year_s;
    cal_mdhms_t         nxt_s;

    cal_days_in_month #(.YEAR_W(YEAR_W)) u_run_dim (
        .month (mdhms_r.month),
        .year  (year_r),
        .days  (run_dim_s)
    );

    cal_days_in_month #(.YEAR_W(YEAR_W)) u_set_dim (
        .month (set_month),
        .year  (set_year),
        .days  (set_dim_s)
    );

    assign tick_s   = (presc_r == PRESC_LAST);
    assign set_ok_s = (set_month >= MONTH_MIN) && (set_month <= MONTH_MAX) &&
                      (set_day >= DAY_MIN) && (set_day <= set_dim_s) &&
                      (set_hour <= HOUR_MAX) && (set_min <= MIN_MAX) &&
                      (set_sec <= SEC_MAX);
    assign load_s    = set_valid && set_ok_s;
    // A valid load swallows a coincident tick.
    assign advance_s = tick_s && !load_s;

    // One-second advance with the full carry chain resolved in one edge.
    // Limits are tested with >= so a corrupted field still recovers.
    always_comb begin
        nxt_year_s = year_r;
        nxt_s      = mdhms_r;
        if (advance_s) begin
            if (mdhms_r.sec >= SEC_MAX) begin
                nxt_s.sec = 6'd0;
                if (mdhms_r.min >= MIN_MAX) begin
                    nxt_s.min = 6'd0;
                    if (mdhms_r.hour >= HOUR_MAX) begin
                        nxt_s.hour = 5'd0;
                        if (mdhms_r.day >= run_dim_s) begin
                            nxt_s.day = DAY_MIN;
                            if (mdhms_r.month >= MONTH_MAX) begin
                                nxt_s.month = MONTH_MIN;
                                if (year_r == YEAR_LAST) begin
                                    nxt_year_s = YEAR_START;
                                end else begin
                                    nxt_year_s = year_r + YEAR_ONE;
                                end
                            end else begin
                                nxt_s.month = mdhms_r.month + 4'd1;
                            end
                        end else begin
                            nxt_s.day = mdhms_r.day + 5'd1;
                        end
                    end else begin
                        nxt_s.hour = mdhms_r.hour + 5'd1;
                    end
                end else begin
                    nxt_s.min = mdhms_r.min + 6'd1;
                end
            end else begin
                nxt_s.sec = mdhms_r.sec + 6'd1;
            end
        end else begin
            nxt_s = mdhms_r;
        end
    end

    // Alarm compares the post-tick time against the alarm value held before this edge.
    assign hit_s = advance_s && alarm_en &&
                   (nxt_s.hour == alarm_hour_r) &&
                   (nxt_s.min == alarm_min_r) &&
                   (nxt_s.sec == 6'd0);

    // Prescaler, date/time state, alarm registers and output pulses.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (KEY) begin
            presc_r      <= {PRESC_W{1'b0}};
            year_r       <= YEAR_START;
            mdhms_r      <= '{month: MONTH_MIN, day: DAY_MIN, hour: 5'd0, min: 6'd0, sec: 6'd0};
            alarm_hour_r <= 5'd0;
            alarm_min_r  <= 6'd0;
            sec_tick_r   <= 1'b0;
            set_err_r    <= 1'b0;
            alarm_hit_r  <= 1'b0;
        end else begin
            if (load_s) begin
                presc_r <= {PRESC_W{1'b0}};
                year_r  <= set_year;
                mdhms_r <= '{month: set_month, day: set_day, hour: set_hour,
                             min: set_min, sec: set_sec};
            end else begin
                if (tick_s) begin
                    presc_r <= {PRESC_W{1'b0}};
                end else begin
                    presc_r <= presc_r + PRESC_ONE;
                end
                year_r  <= nxt_year_s;
                mdhms_r <= nxt_s;
            end
            if (alarm_we) begin
                alarm_hour_r <= alarm_hour;
                alarm_min_r  <= alarm_min;
            end else begin
                alarm_hour_r <= alarm_hour_r;
                alarm_min_r  <= alarm_min_r;
            end
            sec_tick_r  <= advance_s;
            set_err_r   <= set_valid && !set_ok_s;
            alarm_hit_r <= hit_s;
        end
    end

    assign out_year  = year_r;
    assign out_month = mdhms_r.month;
    assign out_day   = mdhms_r.day;
    assign out_hour  = mdhms_r.hour;
    assign out_min   = mdhms_r.min;
    assign out_sec   = mdhms_r.sec;
    assign sec_tick  = sec_tick_r;
    assign set_err   = set_err_r;
    assign alarm_hit = alarm_hit_r;

endmodule

// File: tb/tb_calendar_clock_alarm.sv
// Self-checking bench for calendar_clock_alarm (DIV_CONST=10).
// A seconds-of-day / day-counting model predicts every output each cycle;
// directed scenarios add literal expectations for key boundary results.
module tb_calendar_clock_alarm;

    localparam int DIV   = 10;
    localparam int YW    = 12;
    localparam int YINIT = 2000;

    logic          clk = 1'b0;
    logic          KEY;
    logic          set_valid;
    logic [YW-1:0] set_year;
    logic [3:0]    set_month;
    logic [4:0]    set_day;
    logic [4:0]    set_hour;
    logic [5:0]    set_min;
    logic [5:0]    set_sec;
    logic          alarm_we;
    logic [4:0]    alarm_hour;
    logic [5:0]    alarm_min;
    logic          alarm_en;
    logic [YW-1:0] out_year;
    logic [3:0]    out_month;
    logic [4:0]    out_day;
    logic [4:0]    out_hour;
    logic [5:0]    out_min;
    logic [5:0]    out_sec;
    logic          sec_tick;
    logic          set_err;
    logic          alarm_hit;

    always #5 clk = ~clk;

    calendar_clock_alarm #(
        .DIV_CONST (DIV),
        .YEAR_W    (YW),
        .YEAR_INIT (YINIT)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .KEY           (KEY),
        .set_valid     (set_valid),
        .set_year      (set_year),
        .set_month     (set_month),
        .set_day       (set_day),
        .set_hour      (set_hour),
        .set_min       (set_min),
        .set_sec       (set_sec),
        .alarm_we      (alarm_we),
        .alarm_hour    (alarm_hour),
        .alarm_min     (alarm_min),
        .alarm_en      (alarm_en),
        .out_year      (out_year),
        .out_month     (out_month),
        .out_day       (out_day),
        .out_hour      (out_hour),
        .out_min       (out_min),
        .out_sec       (out_sec),
        .sec_tick      (sec_tick),
        .set_err       (set_err),
        .alarm_hit     (alarm_hit)
    );

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_presc, m_year, m_month, m_day, m_hour, m_min, m_sec, m_ah, m_am;
    int m_tick, m_err, m_hit;
    // Observed pulse counters
    int tick_seen, hit_seen, err_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dim(input int mo, input int y);
        int tab [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        bit leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        if (mo < 1 || mo > 12) return 31;
        if (mo == 2 && leap) return 29;
        return tab[mo-1];
    endfunction

    task automatic model_next_day();
        m_day++;
        if (m_day > dim(m_month, m_year)) begin
            m_day = 1;
            m_month++;
            if (m_month > 12) begin
                m_month = 1;
                if (m_year == (1 << YW) - 1) m_year = YINIT;
                else m_year++;
            end
        end
    endtask

    task automatic model_add_second();
        int sod;
        sod = m_hour * 3600 + m_min * 60 + m_sec + 1;
        if (sod >= 86400) begin
            sod = 0;
            model_next_day();
        end
        m_hour = sod / 3600;
        m_min  = (sod / 60) % 60;
        m_sec  = sod % 60;
    endtask

    // Predict the state after the coming edge from the current inputs.
    task automatic model_step();
        bit ok, ld, tk;
        if (KEY) begin
            m_presc = 0; m_year = YINIT; m_month = 1; m_day = 1;
            m_hour = 0; m_min = 0; m_sec = 0; m_ah = 0; m_am = 0;
            m_tick = 0; m_err = 0; m_hit = 0;
        end else begin
            ok = (int'(set_month) >= 1) && (int'(set_month) <= 12) &&
                 (int'(set_day) >= 1) &&
                 (int'(set_day) <= dim(int'(set_month), int'(set_year))) &&
                 (int'(set_hour) <= 23) && (int'(set_min) <= 59) && (int'(set_sec) <= 59);
            ld = set_valid && ok;
            tk = (m_presc == DIV - 1);
            m_err  = (set_valid && !ok) ? 1 : 0;
            m_tick = (tk && !ld) ? 1 : 0;
            m_hit  = 0;
            if (ld) begin
                m_presc = 0;
                m_year = int'(set_year); m_month = int'(set_month); m_day = int'(set_day);
                m_hour = int'(set_hour); m_min = int'(set_min); m_sec = int'(set_sec);
            end else if (tk) begin
                m_presc = 0;
                model_add_second();
                if (alarm_en && m_hour == m_ah && m_min == m_am && m_sec == 0) m_hit = 1;
            end else begin
                m_presc++;
            end
            if (alarm_we) begin
                m_ah = int'(alarm_hour);
                m_am = int'(alarm_min);
            end
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("out_year",  int'(out_year),  m_year);
        chk("out_month", int'(out_month), m_month);
        chk("out_day",   int'(out_day),   m_day);
        chk("out_hour",  int'(out_hour),  m_hour);
        chk("out_min",   int'(out_min),   m_min);
        chk("out_sec",   int'(out_sec),   m_sec);
        chk("sec_tick",  int'(sec_tick),  m_tick);
        chk("set_err",   int'(set_err),   m_err);
        chk("alarm_hit", int'(alarm_hit), m_hit);
        if (sec_tick)  tick_seen++;
        if (alarm_hit) hit_seen++;
        if (set_err)   err_seen++;
    endtask

    task automatic wait_tick(output int n);
        bit got;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            n++;
            if (sec_tick) got = 1'b1;
        end
        if (!got) chk("tick_timeout", 0, 1);
    endtask

    task automatic drive_set(input int y, input int mo, input int d,
                             input int h, input int mi, input int s);
        set_year  = YW'(y);
        set_month = 4'(mo);
        set_day   = 5'(d);
        set_hour  = 5'(h);
        set_min   = 6'(mi);
        set_sec   = 6'(s);
    endtask

    task automatic do_load(input int y, input int mo, input int d,
                           input int h, input int mi, input int s);
        drive_set(y, mo, d, h, mi, s);
        set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
    endtask

    task automatic expect_time(input string tag, input int y, input int mo, input int d,
                               input int h, input int mi, input int s);
        chk({tag, "_year"},  int'(out_year),  y);
        chk({tag, "_month"}, int'(out_month), mo);
        chk({tag, "_day"},   int'(out_day),   d);
        chk({tag, "_hour"},  int'(out_hour),  h);
        chk({tag, "_min"},   int'(out_min),   mi);
        chk({tag, "_sec"},   int'(out_sec),   s);
    endtask

    initial begin
        int n;
        int t0;
        KEY = 1'b1; set_valid = 1'b0; alarm_we = 1'b0; alarm_en = 1'b0;
        alarm_hour = 5'd0; alarm_min = 6'd0;
        drive_set(0, 0, 0, 0, 0, 0);
        tick_seen = 0; hit_seen = 0; err_seen = 0;

        // Reset and first tick
        cycle();
        cycle();
        KEY = 1'b0;
        expect_time("reset", 2000, 1, 1, 0, 0, 0);
        chk("reset_tick", int'(sec_tick), 0);
        wait_tick(n);
        chk("first_tick_latency", n, 10);
        chk("first_tick_sec", int'(out_sec), 1);

        // Leap-year rollovers
        do_load(2024, 2, 28, 23, 59, 59);
        wait_tick(n);
        chk("load_tick_latency", n, 10);
        expect_time("leap2024", 2024, 2, 29, 0, 0, 0);
        do_load(2100, 2, 28, 23, 59, 59);
        wait_tick(n);
        expect_time("noleap2100", 2100, 3, 1, 0, 0, 0);
        do_load(2000, 2, 28, 23, 59, 59);
        wait_tick(n);
        expect_time("leap2000", 2000, 2, 29, 0, 0, 0);

        // Year rollovers
        t0 = tick_seen;
        do_load(1999, 12, 31, 23, 59, 59);
        wait_tick(n);
        expect_time("newyear", 2000, 1, 1, 0, 0, 0);
        chk("newyear_single_tick", tick_seen - t0, 1);
        do_load(4095, 12, 31, 23, 59, 59);
        wait_tick(n);
        expect_time("yearwrap", 2000, 1, 1, 0, 0, 0);

        // Rejected loads: prescaler is 0 here, three rejects then the tick
        drive_set(2023, 13, 1, 0, 0, 0);
        set_valid = 1'b1;
        cycle();
        chk("err_month13", int'(set_err), 1);
        drive_set(2023, 4, 31, 0, 0, 0);
        cycle();
        chk("err_apr31", int'(set_err), 1);
        drive_set(2023, 2, 29, 0, 0, 0);
        cycle();
        chk("err_feb29", int'(set_err), 1);
        set_valid = 1'b0;
        expect_time("err_unchanged", 2000, 1, 1, 0, 0, 0);
        wait_tick(n);
        chk("err_tick_schedule", n, 7);
        chk("err_tick_sec", int'(out_sec), 1);

        // Load colliding with the tick
        for (int i = 0; i < 9; i++) cycle();
        do_load(2010, 6, 15, 12, 0, 0);
        chk("collide_no_tick", int'(sec_tick), 0);
        expect_time("collide", 2010, 6, 15, 12, 0, 0);
        wait_tick(n);
        chk("collide_next_tick", n, 10);
        chk("collide_sec", int'(out_sec), 1);

        // Alarm enabled: exactly one hit, together with the tick
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_we = 1'b1; alarm_en = 1'b1;
        cycle();
        alarm_we = 1'b0;
        hit_seen = 0;
        do_load(2001, 5, 5, 7, 29, 59);
        wait_tick(n);
        chk("alarm_hit_on_tick", int'(alarm_hit), 1);
        for (int i = 0; i < 12; i++) cycle();
        chk("alarm_hit_once", hit_seen, 1);

        // Alarm disabled
        alarm_en = 1'b0;
        hit_seen = 0;
        do_load(2001, 5, 5, 7, 29, 59);
        wait_tick(n);
        cycle();
        chk("alarm_disabled", hit_seen, 0);

        // Loading the alarm time directly does not fire
        alarm_en = 1'b1;
        hit_seen = 0;
        do_load(2001, 5, 5, 7, 30, 0);
        for (int i = 0; i < 25; i++) cycle();
        chk("alarm_load_no_hit", hit_seen, 0);

        // Alarm rewrite on the matching tick still uses the old value
        do_load(2001, 5, 5, 7, 29, 59);
        for (int i = 0; i < 9; i++) cycle();
        alarm_hour = 5'd8; alarm_min = 6'd0; alarm_we = 1'b1;
        cycle();
        alarm_we = 1'b0;
        chk("alarm_old_tick", int'(sec_tick), 1);
        chk("alarm_old_hit", int'(alarm_hit), 1);
        do_load(2001, 5, 5, 7, 59, 59);
        wait_tick(n);
        chk("alarm_new_hit", int'(alarm_hit), 1);
        expect_time("alarm_new", 2001, 5, 5, 8, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
